// File: rtl/load_store_unit_if.sv
// Pipeline request/response and data-memory signals of the load/store unit.
// The LSU takes the master modport; the pipeline and memory side take slave.
interface load_store_unit_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_data_i;

  modport master (
    input  req_valid_i, req_write_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    output mem_addr_o, mem_data_o, mem_read_o, mem_write_o,
    input  mem_data_i
  );

  modport slave (
    output req_valid_i, req_write_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    input  mem_addr_o, mem_data_o, mem_read_o, mem_write_o,
    output mem_data_i
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses onto a word-wide memory, sub-word stores by read-modify-write.
// Optional macro LSU_PERF_CNT_EN adds load_cnt_o/store_cnt_o completion counters.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic clk_i,
  input  logic rst_i,
  load_store_unit_if.master bus
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0] load_cnt_o,
  output logic [31:0] store_cnt_o
`endif
);
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, STORE, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        write_q, write_d, unsigned_q, unsigned_d;
  logic        ready_d, resp_valid_d, resp_err_d, mem_read_d, mem_write_d;
  logic [31:0] resp_rdata_d, mem_addr_d, mem_data_d;
  logic [2:0]  req_bytes;
  logic [32:0] req_end;
  logic        req_err;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext, merged;

  // Request legality: size, alignment and range against the memory size
  always_comb begin
    req_bytes = 3'd0;
    case (bus.req_size_i)
      2'd0:    req_bytes = 3'd1;
      2'd1:    req_bytes = 3'd2;
      2'd2:    req_bytes = 3'd4;
      default: req_bytes = 3'd0;
    endcase
    req_end = {1'b0, bus.req_addr_i} + 33'(req_bytes);
    req_err = (bus.req_size_i == 2'd3)
           || ((bus.req_size_i == 2'd1) && bus.req_addr_i[0])
           || ((bus.req_size_i == 2'd2) && (bus.req_addr_i[1:0] != 2'b00))
           || (req_end > 33'(MEM_BYTES));
  end

  // Lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    lane_b = 8'd0;
    merged = bus.mem_data_i;
    case (addr_q[1:0])
      2'd0:    lane_b = bus.mem_data_i[7:0];
      2'd1:    lane_b = bus.mem_data_i[15:8];
      2'd2:    lane_b = bus.mem_data_i[23:16];
      default: lane_b = bus.mem_data_i[31:24];
    endcase
    lane_h = addr_q[1] ? bus.mem_data_i[31:16] : bus.mem_data_i[15:0];
    case (size_q)
      2'd0:    load_ext = unsigned_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'd1:    load_ext = unsigned_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_ext = bus.mem_data_i;
    endcase
    if (size_q == 2'd0) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  // Next state; registered outputs are derived from the state being entered
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    write_d      = write_q;
    unsigned_d   = unsigned_q;
    wdata_d      = wdata_q;
    resp_rdata_d = bus.resp_rdata_o;
    resp_err_d   = bus.resp_err_o;
    mem_data_d   = 32'd0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          addr_d       = bus.req_addr_i;
          size_d       = bus.req_size_i;
          write_d      = bus.req_write_i;
          unsigned_d   = bus.req_unsigned_i;
          wdata_d      = bus.req_wdata_i;
          resp_rdata_d = 32'd0;
          resp_err_d   = req_err;
          if (req_err) begin
            state_d = DONE;
          end else if (!bus.req_write_i) begin
            state_d = LOAD;
          end else if (bus.req_size_i == 2'd2) begin
            state_d    = STORE;
            mem_data_d = bus.req_wdata_i;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      LOAD: begin
        resp_rdata_d = load_ext;
        state_d      = DONE;
      end
      RMW_RD: begin
        mem_data_d = merged;
        state_d    = STORE;
      end
      STORE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d      = (state_d == IDLE);
    resp_valid_d = (state_d == DONE);
    mem_read_d   = (state_d == LOAD) || (state_d == RMW_RD);
    mem_write_d  = (state_d == STORE);
    mem_addr_d   = (mem_read_d || mem_write_d) ? {addr_d[31:2], 2'b00} : 32'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      addr_q           <= 32'd0;
      size_q           <= 2'd0;
      write_q          <= 1'b0;
      unsigned_q       <= 1'b0;
      wdata_q          <= 32'd0;
      bus.req_ready_o  <= 1'b1;
      bus.resp_valid_o <= 1'b0;
      bus.resp_rdata_o <= 32'd0;
      bus.resp_err_o   <= 1'b0;
      bus.mem_read_o   <= 1'b0;
      bus.mem_write_o  <= 1'b0;
      bus.mem_addr_o   <= 32'd0;
      bus.mem_data_o   <= 32'd0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      size_q           <= size_d;
      write_q          <= write_d;
      unsigned_q       <= unsigned_d;
      wdata_q          <= wdata_d;
      bus.req_ready_o  <= ready_d;
      bus.resp_valid_o <= resp_valid_d;
      bus.resp_rdata_o <= resp_rdata_d;
      bus.resp_err_o   <= resp_err_d;
      bus.mem_read_o   <= mem_read_d;
      bus.mem_write_o  <= mem_write_d;
      bus.mem_addr_o   <= mem_addr_d;
      bus.mem_data_o   <= mem_data_d;
    end
  end

`ifdef LSU_PERF_CNT_EN
  // Successful completions only; errors are counted by neither
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      load_cnt_o  <= 32'd0;
      store_cnt_o <= 32'd0;
    end else if ((state_q == DONE) && !bus.resp_err_o) begin
      if (write_q) store_cnt_o <= store_cnt_o + 32'd1;
      else         load_cnt_o  <= load_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural 128-byte memory.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_clr = 1'b1;
  int   checks = 0;
  int   fails = 0;
  int   viol = 0;
  logic [31:0] mem [0:31];

  load_store_unit_if bus ();

`ifdef LSU_PERF_CNT_EN
  logic [31:0] load_cnt, store_cnt;
`endif

  load_store_unit #(.MEM_BYTES(128)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef LSU_PERF_CNT_EN
    ,
    .load_cnt_o  (load_cnt),
    .store_cnt_o (store_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign bus.mem_data_i = mem[bus.mem_addr_o[6:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
    end else if (bus.mem_write_o) begin
      mem[bus.mem_addr_o[6:2]] <= bus.mem_data_o;
    end
  end

  // Enables never overlap; address/data are zero while the memory port is idle
  always @(negedge clk) begin
    if (bus.mem_read_o && bus.mem_write_o) viol <= viol + 1;
    if (!bus.mem_read_o && !bus.mem_write_o && (bus.mem_addr_o != 32'd0 || bus.mem_data_o != 32'd0))
      viol <= viol + 1;
  end

  // Drive one request, then count edges until resp_valid_o (lat = 1 means first edge after handshake)
  task automatic issue(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] wd, output int lat, output logic [31:0] rd,
                       output logic er, output int wr_cyc, output int rd_cyc);
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_write_i = w;
    bus.req_size_i = sz;
    bus.req_unsigned_i = u;
    bus.req_addr_i = a;
    bus.req_wdata_i = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    lat = 1;
    wr_cyc = 0;
    rd_cyc = 0;
    while (!bus.resp_valid_o && lat < 10) begin
      if (bus.mem_write_o) wr_cyc++;
      if (bus.mem_read_o) rd_cyc++;
      @(negedge clk);
      lat++;
    end
    rd = bus.resp_rdata_o;
    er = bus.resp_err_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mem_clr = 1'b0;
    checks++;
    if (bus.req_ready_o !== 1'b1) begin
      fails++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready_o);
    end
    checks++;
    if ({bus.resp_valid_o, bus.resp_err_o, bus.mem_read_o, bus.mem_write_o} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got %b expected 0000",
                        {bus.resp_valid_o, bus.resp_err_o, bus.mem_read_o, bus.mem_write_o});
    end
    checks++;
    if ({bus.resp_rdata_o, bus.mem_addr_o, bus.mem_data_o} !== 96'd0) begin
      fails++; $display("FAIL reset_buses: rdata %h addr %h data %h expected 0",
                        bus.resp_rdata_o, bus.mem_addr_o, bus.mem_data_o);
    end
  endtask

  task automatic test_word();
    int lat, wc, rc; logic [31:0] rd; logic er;
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h8BADF00D, lat, rd, er, wc, rc);
    checks++;
    if (lat !== 2) begin fails++; $display("FAIL sw_latency: got %0d expected 2", lat); end
    checks++;
    if (wc !== 1 || rc !== 0) begin fails++; $display("FAIL sw_enables: wr %0d rd %0d expected 1 0", wc, rc); end
    checks++;
    if (mem[4] !== 32'h8BADF00D) begin fails++; $display("FAIL sw_mem: got %h expected 8badf00d", mem[4]); end
    checks++;
    if (rd !== 32'd0 || er !== 1'b0) begin fails++; $display("FAIL sw_resp: rdata %h err %b expected 0 0", rd, er); end
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, er, wc, rc);
    checks++;
    if (rd !== 32'h8BADF00D || er !== 1'b0) begin
      fails++; $display("FAIL lw_data: rdata %h err %b expected 8badf00d 0", rd, er);
    end
    checks++;
    if (lat !== 2 || rc !== 1) begin fails++; $display("FAIL lw_timing: lat %0d rd %0d expected 2 1", lat, rc); end
    @(negedge clk);
    checks++;
    if (bus.resp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
      fails++; $display("FAIL resp_pulse: valid %b ready %b expected 0 1", bus.resp_valid_o, bus.req_ready_o);
    end
  endtask

  task automatic test_byte_rmw();
    int lat, wc, rc; logic [31:0] rd; logic er;
    issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AA, lat, rd, er, wc, rc);
    checks++;
    if (lat !== 3 || wc !== 1 || rc !== 1) begin
      fails++; $display("FAIL sb_timing: lat %0d wr %0d rd %0d expected 3 1 1", lat, wc, rc);
    end
    checks++;
    if (mem[4] !== 32'hAAADF00D) begin fails++; $display("FAIL sb_mem: got %h expected aaadf00d", mem[4]); end
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, lat, rd, er, wc, rc);
    checks++;
    if (rd !== 32'hFFFFFFAA) begin fails++; $display("FAIL lb_sign: got %h expected ffffffaa", rd); end
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, lat, rd, er, wc, rc);
    checks++;
    if (rd !== 32'h000000AA) begin fails++; $display("FAIL lbu_zero: got %h expected 000000aa", rd); end
  endtask

  task automatic test_half_rmw();
    int lat, wc, rc; logic [31:0] rd; logic er;
    issue(1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234, lat, rd, er, wc, rc);
    checks++;
    if (mem[4] !== 32'h1234F00D || lat !== 3) begin
      fails++; $display("FAIL sh_mem: got %h lat %0d expected 1234f00d 3", mem[4], lat);
    end
    issue(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, lat, rd, er, wc, rc);
    checks++;
    if (rd !== 32'hFFFFF00D) begin fails++; $display("FAIL lh_lo: got %h expected fffff00d", rd); end
    issue(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, lat, rd, er, wc, rc);
    checks++;
    if (rd !== 32'h0000F00D) begin fails++; $display("FAIL lhu_lo: got %h expected 0000f00d", rd); end
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, lat, rd, er, wc, rc);
    checks++;
    if (rd !== 32'h00001234) begin fails++; $display("FAIL lh_hi: got %h expected 00001234", rd); end
  endtask

  task automatic test_errors();
    int lat, wc, rc, diffs; logic [31:0] rd; logic er;
    logic [31:0] snap [0:31];
    logic        ew [0:4];
    logic [1:0]  es [0:4];
    logic [31:0] ea [0:4];
    ew = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    es = '{2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    ea = '{32'h06, 32'h11, 32'h7E, 32'h80, 32'h10};
    snap = mem;
    for (int k = 0; k < 5; k++) begin
      issue(ew[k], es[k], 1'b0, ea[k], 32'hDEADBEEF, lat, rd, er, wc, rc);
      checks++;
      if (er !== 1'b1 || rd !== 32'd0 || lat !== 1 || wc !== 0 || rc !== 0) begin
        fails++; $display("FAIL err_case%0d: err %b rdata %h lat %0d wr %0d rd %0d expected 1 0 1 0 0",
                          k, er, rd, lat, wc, rc);
      end
    end
    diffs = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== snap[i]) diffs++;
    checks++;
    if (diffs !== 0) begin fails++; $display("FAIL err_mem_untouched: %0d words changed expected 0", diffs); end
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, er, wc, rc);
    checks++;
    if (er !== 1'b0 || rd !== 32'h1234F00D) begin
      fails++; $display("FAIL err_clear: err %b rdata %h expected 0 1234f00d", er, rd);
    end
  endtask

  task automatic test_boundary();
    int lat, wc, rc; logic [31:0] rd; logic er;
    issue(1'b1, 2'd0, 1'b0, 32'h7F, 32'hFFFFFF80, lat, rd, er, wc, rc);
    checks++;
    if (er !== 1'b0 || mem[31] !== 32'h80000000) begin
      fails++; $display("FAIL sb_top: err %b mem %h expected 0 80000000", er, mem[31]);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h7C, 32'h0, lat, rd, er, wc, rc);
    checks++;
    if (er !== 1'b0 || rd !== 32'h80000000) begin
      fails++; $display("FAIL lw_top: err %b rdata %h expected 0 80000000", er, rd);
    end
    issue(1'b0, 2'd0, 1'b0, 32'h7F, 32'h0, lat, rd, er, wc, rc);
    checks++;
    if (rd !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_top: got %h expected ffffff80", rd); end
  endtask

  task automatic test_reset_midop();
    int lat, wc, rc, vc; logic [31:0] rd; logic er;
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_write_i = 1'b1;
    bus.req_size_i = 2'd0;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i = 32'h20;
    bus.req_wdata_i = 32'h55;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    checks++;
    if (bus.mem_read_o !== 1'b1) begin fails++; $display("FAIL rmw_rd_entered: read %b expected 1", bus.mem_read_o); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.req_ready_o !== 1'b1 || bus.mem_write_o !== 1'b0) begin
      fails++; $display("FAIL midop_ready: ready %b write %b expected 1 0", bus.req_ready_o, bus.mem_write_o);
    end
    wc = 0;
    vc = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.mem_write_o) wc++;
      if (bus.resp_valid_o) vc++;
      @(negedge clk);
    end
    checks++;
    if (wc !== 0 || vc !== 0 || mem[8] !== 32'd0) begin
      fails++; $display("FAIL midop_quiet: writes %0d resps %0d mem %h expected 0 0 0", wc, vc, mem[8]);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, lat, rd, er, wc, rc);
    checks++;
    if (rd !== 32'd0 || er !== 1'b0 || lat !== 2) begin
      fails++; $display("FAIL midop_lw: rdata %h err %b lat %0d expected 0 0 2", rd, er, lat);
    end
  endtask

`ifdef LSU_PERF_CNT_EN
  task automatic test_perf();
    int lat, wc, rc; logic [31:0] rd; logic er;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(1'b1, 2'd2, 1'b0, 32'h40, 32'h11223344, lat, rd, er, wc, rc);
    issue(1'b1, 2'd0, 1'b0, 32'h41, 32'h99, lat, rd, er, wc, rc);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, lat, rd, er, wc, rc);
    issue(1'b0, 2'd1, 1'b0, 32'h42, 32'h0, lat, rd, er, wc, rc);
    issue(1'b0, 2'd2, 1'b0, 32'h41, 32'h0, lat, rd, er, wc, rc);
    issue(1'b0, 2'd0, 1'b1, 32'h43, 32'h0, lat, rd, er, wc, rc);
    @(negedge clk);
    checks++;
    if (load_cnt !== 32'd3 || store_cnt !== 32'd2) begin
      fails++; $display("FAIL perf_counts: loads %0d stores %0d expected 3 2", load_cnt, store_cnt);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (load_cnt !== 32'd0 || store_cnt !== 32'd0) begin
      fails++; $display("FAIL perf_reset: loads %0d stores %0d expected 0 0", load_cnt, store_cnt);
    end
  endtask
`endif

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_write_i = 1'b0;
    bus.req_size_i = 2'd0;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i = 32'd0;
    bus.req_wdata_i = 32'd0;
    test_reset();
    test_word();
    test_byte_rmw();
    test_half_rmw();
    test_errors();
    test_boundary();
    test_reset_midop();
`ifdef LSU_PERF_CNT_EN
    test_perf();
`endif
    checks++;
    if (viol !== 0) begin fails++; $display("FAIL mem_port_rules: %0d violations expected 0", viol); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator for the word-wide, byte-addressed data memory (combinational read, posedge write, little-endian byte lanes).
- Sits between the pipeline MEM stage and the data memory, and takes one load or store request at a time over a valid/ready handshake.
- Converts byte and halfword accesses into aligned word accesses. Sub-word stores use read-modify-write.
- Returns load data sign- or zero-extended, and flags misaligned or out-of-range requests without touching memory.

Parameters:
- MEM_BYTES, 128, memory size in bytes; legal byte addresses are 0..MEM_BYTES-1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  unit can accept a request
- req_write_i  in  1  1 = store, 0 = load
- req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal (treated as error)
- req_unsigned_i  in  1  zero-extend the load result
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data; low bits are used for sub-word stores
- resp_valid_o  out  1  one-cycle completion pulse
- resp_rdata_o  out  32  extended load data; 0 for stores and errors
- resp_err_o  out  1  misaligned, out-of-range, or illegal-size request
- mem_addr_o  out  32  word-aligned address to memory
- mem_data_o  out  32  write data to memory
- mem_read_o  out  1  memory read enable
- mem_write_o  out  1  memory write enable, sampled by memory at posedge
- mem_data_i  in  32  read data from memory, valid in the same cycle

Behaviour:
- Clocking: one clock, clk_i. rst_i is synchronous and active-high.
- Reset: state = IDLE. req_ready_o = 1. resp_valid_o, resp_rdata_o, resp_err_o, mem_read_o, mem_write_o, mem_addr_o and mem_data_o are all 0.
- FSM states: IDLE, LOAD, RMW_RD, STORE, DONE.
- IDLE:
  - req_ready_o = 1; it is 0 in every other state.
  - A handshake occurs when req_valid_i && req_ready_o. On handshake, register addr, size, write, unsigned and wdata.
  - Error check: error if size = 3, or half with addr[0] != 0, or word with addr[1:0] != 0, or addr + bytes > MEM_BYTES.
  - Next state: error -> DONE with err = 1; load -> LOAD; word store -> STORE; byte/half store -> RMW_RD.
- LOAD:
  - Drive mem_read_o = 1 and mem_addr_o = {addr[31:2], 2'b00}.
  - Capture mem_data_i at the clock edge.
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Extract the lane; sign-extend unless unsigned; word passes through.
  - Register the result into resp_rdata_o. Next state: DONE.
- RMW_RD: drive a read as in LOAD; capture the word into the merge register. Next state: STORE.
- STORE:
  - Drive mem_write_o = 1, the aligned mem_addr_o, and mem_data_o.
  - Word store: mem_data_o = wdata.
  - Byte/half store: mem_data_o = captured word with only the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
  - Next state: DONE.
- DONE: resp_valid_o = 1 for exactly one cycle, with resp_rdata_o and resp_err_o stable. Next state: IDLE.
- Idle outputs: mem_addr_o and mem_data_o are 0 whenever mem_read_o and mem_write_o are both 0. mem_read_o and mem_write_o are never both 1.
- Latency from handshake edge to resp_valid_o: load 2 cycles, word store 2, sub-word store 3, error 1.
- Back-to-back requests: a new request is accepted 1 cycle after resp_valid_o, i.e. in IDLE.
- Responses have no back-pressure.
- Errors:
  - No memory enable is asserted, and memory is unmodified.
  - resp_rdata_o = 0.
  - resp_err_o is cleared on the next accepted non-error request.
- Reset mid-operation: FSM returns to IDLE on the reset edge.
  - A write enable asserted in the cycle of the reset edge still completes, since memory samples it at that edge.
  - A write not yet reached (reset in LOAD or RMW_RD) never happens, and no response is issued.
- req_valid_i while busy is ignored (ready = 0). The requester must hold the request.

Optional Feature:
- Macro: LSU_PERF_CNT_EN.
- Defined: adds outputs load_cnt_o [31:0] and store_cnt_o [31:0].
  - Each increments in DONE for a successful (non-error) load or store respectively.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Word store/load: sw 0x8BADF00D @0x10 -> mem_write_o for exactly 1 cycle, memory word[4] = 0x8BADF00D, resp 2 cycles after accept. Then lw @0x10 -> resp_rdata_o = 0x8BADF00D, err = 0.
- Byte RMW: sb 0x000000AA @0x13 -> RMW_RD then STORE, word = 0xAAADF00D, resp at 3 cycles. Then lb @0x13 -> 0xFFFFFFAA; lbu @0x13 -> 0x000000AA.
- Half RMW: sh 0x1234 @0x12 -> word = 0x1234F00D. Then lh @0x10 -> 0xFFFFF00D; lhu @0x10 -> 0x0000F00D; lh @0x12 -> 0x00001234.
- Errors, each -> resp_err_o = 1 at 1 cycle, rdata = 0, no memory enable ever asserted, memory unchanged:
  - lw @0x06
  - sh @0x11
  - lw @0x7E
  - lw @0x80
  - size = 3
- Reset mid-op: sb 0x55 @0x20, rst_i pulsed in RMW_RD -> no mem_write_o, no resp_valid_o, req_ready_o = 1 next cycle, word @0x20 unchanged = 0. A following lw @0x20 -> 0.
- With LSU_PERF_CNT_EN: 3 loads, 2 stores, 1 error -> load_cnt_o = 3, store_cnt_o = 2. After reset both = 0.
